// File: rtl/pc_seq_unit.sv
// Program-counter unit: PC register, next-PC selection, exception redirect and misalignment halt.
// Optional build macro PC_EPC_EN adds the epc register and the eret (npc_sel=4) return path.
module pc_seq_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_4180)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_wr,
  input  logic [2:0]        npc_sel,
  input  logic [15:0]       br_offset,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              exc_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pc_valid,
  output logic              misalign,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] br_ext;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_ok;

  assign state_dbg = state;
  assign pc_plus4  = pc + ADDR_W'(4);
  // Sign-extended word offset; upper bits beyond ADDR_W drop out mod 2^ADDR_W.
  assign br_ext    = ADDR_W'({{14{br_offset[15]}}, br_offset, 2'b00});

  generate
    if (ADDR_W > 28) begin : g_jump_hi
      assign jump_tgt = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
    end else begin : g_jump_lo
      assign jump_tgt = {jump_index, 2'b00};
    end
  endgenerate

`ifdef PC_EPC_EN
  logic [ADDR_W-1:0] epc_q;
  assign epc = epc_q;
`else
  assign epc = '0;
`endif

  // tgt_ok is low for reserved selects, which leave the PC untouched without error.
  always_comb begin
    tgt    = '0;
    tgt_ok = 1'b0;
    case (npc_sel)
      3'd0: begin tgt = pc_plus4;          tgt_ok = 1'b1; end
      3'd1: begin tgt = pc_plus4 + br_ext; tgt_ok = 1'b1; end
      3'd2: begin tgt = jump_tgt;          tgt_ok = 1'b1; end
      3'd3: begin tgt = jr_target;         tgt_ok = 1'b1; end
`ifdef PC_EPC_EN
      3'd4: begin tgt = epc_q;             tgt_ok = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RST;
      pc       <= '0;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
`ifdef PC_EPC_EN
      epc_q    <= '0;
`endif
    end else begin
      case (state)
        // The boot vector is loaded on leaving RST so it is already visible throughout BOOT.
        ST_RST: begin
          pc       <= RESET_VECTOR;
          pc_valid <= 1'b1;
          state    <= ST_BOOT;
        end
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (exc_req) begin
            pc <= EXC_VECTOR;
`ifdef PC_EPC_EN
            epc_q <= pc;
`endif
          end else if (pc_wr && tgt_ok) begin
            if (tgt[1:0] != 2'b00) begin
              misalign <= 1'b1;
              pc_valid <= 1'b0;
              state    <= ST_HALT;
            end else begin
              pc <= tgt;
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: boot, sequential/branch/jump/jr updates, exception, wrap, reserved selects, misalign halt.
// Exception-return expectations follow PC_EPC_EN when the bench is built with that macro.
module tb_pc_seq_unit;

  localparam int AW = 32;
  localparam logic [1:0] S_RST = 2'd0, S_BOOT = 2'd1, S_RUN = 2'd2, S_HALT = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_wr;
  logic [2:0]    npc_sel;
  logic [15:0]   br_offset;
  logic [25:0]   jump_index;
  logic [AW-1:0] jr_target;
  logic          exc_req;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus4;
  logic          pc_valid;
  logic          misalign;
  logic [AW-1:0] epc;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .pc_wr(pc_wr), .npc_sel(npc_sel),
    .br_offset(br_offset), .jump_index(jump_index), .jr_target(jr_target),
    .exc_req(exc_req), .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .misalign(misalign), .epc(epc), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [2:0] sel, input logic exc);
    pc_wr   = wr;
    npc_sel = sel;
    exc_req = exc;
  endtask

  // One clock edge, then compare every registered output against the queued expectation.
  task automatic step(input string tag, input logic [31:0] e_pc, input logic e_valid,
                      input logic e_mis, input logic [1:0] e_state);
    logic [31:0] e;
    exp_q.push_back(e_pc);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"}, pc, e);
    chk({tag, ".pc_plus4"}, pc_plus4, e + 32'd4);
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e_valid));
    chk({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
    chk({tag, ".state"}, 32'(state_dbg), 32'(e_state));
  endtask

  initial begin
    rst = 1'b1;
    br_offset = '0;
    jump_index = '0;
    jr_target = '0;
    drive(1'b0, 3'd0, 1'b0);

    // Reset held three cycles, then boot with a pending write that BOOT must ignore.
    for (int i = 0; i < 3; i++) step("rst", 32'h0, 1'b0, 1'b0, S_RST);
    chk("rst.epc", epc, 32'h0);
    rst = 1'b0;
    drive(1'b1, 3'd0, 1'b0);
    step("boot", 32'h3000, 1'b1, 1'b0, S_BOOT);
    step("boot_ign", 32'h3000, 1'b1, 1'b0, S_RUN);

    // Sequential and branch.
    step("seq", 32'h3004, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd1, 1'b0); br_offset = 16'hFFFE;
    step("br_neg", 32'h3000, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd0, 1'b0);
    step("seq2", 32'h3004, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd1, 1'b0); br_offset = 16'h0010;
    step("br_pos", 32'h3048, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'h3004;
    step("jr_set", 32'h3004, 1'b1, 1'b0, S_RUN);

    // Jump and jr, then a held cycle.
    drive(1'b1, 3'd2, 1'b0); jump_index = 26'h0000C10;
    step("jump", 32'h3040, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'h3100;
    step("jr", 32'h3100, 1'b1, 1'b0, S_RUN);
    drive(1'b0, 3'd0, 1'b0);
    step("hold", 32'h3100, 1'b1, 1'b0, S_RUN);

    // Exception beats a simultaneous pc_wr; eret depends on the build.
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'h3010;
    step("jr_exc", 32'h3010, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd0, 1'b1);
    step("exc", 32'h4180, 1'b1, 1'b0, S_RUN);
`ifdef PC_EPC_EN
    chk("exc.epc", epc, 32'h3010);
    drive(1'b1, 3'd4, 1'b0);
    step("eret", 32'h3010, 1'b1, 1'b0, S_RUN);
`else
    chk("exc.epc", epc, 32'h0);
    drive(1'b1, 3'd4, 1'b0);
    step("eret_rsv", 32'h4180, 1'b1, 1'b0, S_RUN);
`endif

    // Wrap at the top word address, then reserved selects hold.
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'hFFFF_FFFC;
    step("jr_top", 32'hFFFF_FFFC, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd0, 1'b0);
    step("wrap", 32'h0, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd6, 1'b0);
    step("rsv6", 32'h0, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd5, 1'b0);
    step("rsv5", 32'h0, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd7, 1'b0);
    step("rsv7", 32'h0, 1'b1, 1'b0, S_RUN);

    // Misaligned jr halts; nothing but reset gets out.
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'h3100;
    step("jr_pre", 32'h3100, 1'b1, 1'b0, S_RUN);
    jr_target = 32'h3102;
    step("mis", 32'h3100, 1'b0, 1'b1, S_HALT);
    drive(1'b1, 3'd0, 1'b1);
    step("halt", 32'h3100, 1'b0, 1'b1, S_HALT);
    drive(1'b1, 3'd3, 1'b0); jr_target = 32'h3200;
    step("halt2", 32'h3100, 1'b0, 1'b1, S_HALT);
    rst = 1'b1;
    step("halt_rst", 32'h0, 1'b0, 1'b0, S_RST);

    // Reset in the middle of running aborts the pending write.
    rst = 1'b0;
    drive(1'b0, 3'd0, 1'b0);
    step("reboot", 32'h3000, 1'b1, 1'b0, S_BOOT);
    step("reboot2", 32'h3000, 1'b1, 1'b0, S_RUN);
    drive(1'b1, 3'd0, 1'b0);
    step("seq3", 32'h3004, 1'b1, 1'b0, S_RUN);
    rst = 1'b1;
    step("mid_rst", 32'h0, 1'b0, 1'b0, S_RST);
    chk("mid_rst.epc", epc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
